// File: rtl/mem_stage_ctrl.sv
// MEM stage: EX/MEM consumer, req/ack data bus master, MEM/WB loader.
// Optional access timeout with sticky bus_err: define MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              EXMEM_RegWrite,
  input  logic              EXMEM_MemToReg,
  input  logic              EXMEM_MemRead,
  input  logic              EXMEM_MemWrite,
  input  logic [4:0]        EXMEM_rd,
  input  logic [DATA_W-1:0] EXMEM_npc,
  input  logic [DATA_W-1:0] EXMEM_reg_2,
  input  logic [DATA_W-1:0] EXMEM_ALU_result,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              bus_err,
  output logic              MEMWB_RegWrite,
  output logic              MEMWB_MemToReg,
  output logic [4:0]        MEMWB_rd,
  output logic [DATA_W-1:0] MEMWB_npc,
  output logic [DATA_W-1:0] MEMWB_ALU_result,
  output logic [DATA_W-1:0] MEMWB_mem_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_mem_op;
  logic              w_stall;
  logic              w_tmo;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cap;

  assign w_mem_op  = EXMEM_MemRead | EXMEM_MemWrite;
  assign w_stall   = ((r_state == S_IDLE) & w_mem_op)
                   | (r_state == S_ACCESS);
  // Gate with rstn so the stall drops the instant reset asserts.
  assign mem_stall = rstn & w_stall;
  assign dm_req    = r_req;
  assign dm_we     = r_we;
  assign dm_addr   = r_addr;
  assign dm_wdata  = r_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_bus_err;

  // Abort in the TIMEOUT_CYCLES-th ACCESS cycle unless ack arrives.
  assign w_tmo   = (r_state == S_ACCESS) & ~dm_ack
                 & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = r_bus_err;

  // Access-cycle counter and sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_mem_op)
        r_cnt <= '0;
      else if ((r_state == S_ACCESS) && !dm_ack)
        r_cnt <= r_cnt + 1'b1;
      if (w_tmo)
        r_bus_err <= 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = |TIMEOUT_CYCLES;
  assign w_tmo        = 1'b0;
  assign bus_err      = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_mem_op) w_next = S_ACCESS;
      S_ACCESS: if (dm_ack || w_tmo) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus request registers and captured load data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cap   <= '0;
    end else if ((r_state == S_IDLE) && w_mem_op) begin
      r_req   <= 1'b1;
      r_we    <= EXMEM_MemWrite;
      r_addr  <= EXMEM_ALU_result;
      r_wdata <= EXMEM_reg_2;
    end else if ((r_state == S_ACCESS) && (dm_ack || w_tmo)) begin
      r_req <= 1'b0;
      r_cap <= (dm_ack && !r_we) ? dm_rdata : '0;
    end
  end

  // MEM/WB register: bubble while stalled, else advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      MEMWB_RegWrite   <= 1'b0;
      MEMWB_MemToReg   <= 1'b0;
      MEMWB_rd         <= '0;
      MEMWB_npc        <= '0;
      MEMWB_ALU_result <= '0;
      MEMWB_mem_data   <= '0;
    end else if (w_stall) begin
      MEMWB_RegWrite <= 1'b0;
      MEMWB_MemToReg <= 1'b0;
    end else begin
      MEMWB_RegWrite   <= EXMEM_RegWrite;
      MEMWB_MemToReg   <= EXMEM_MemToReg;
      MEMWB_rd         <= EXMEM_rd;
      MEMWB_npc        <= EXMEM_npc;
      MEMWB_ALU_result <= EXMEM_ALU_result;
      MEMWB_mem_data   <= r_cap;
    end
  end

endmodule
